// File: rtl/cla_pkg.sv
// -----------------------------------------------------------------------------
// cla_pkg
// Shared definitions for the pipelined carry-lookahead adder:
//   - default WIDTH/BLOCK constants and the largest supported geometry
//   - cla_nblk()       : number of lookahead blocks for a WIDTH/BLOCK pair
//   - cla_params_ok()  : legality check used at elaboration by the top level
//   - s1_payload_t     : stage-1 pipeline payload (block P/G, both candidate
//                        sums, effective carry-in and operand sign bits)
// The payload is sized for the largest supported geometry; narrower
// instances zero the upper bits, which synthesis removes as constants.
// -----------------------------------------------------------------------------
package cla_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_BLOCK = 8;

    localparam int MAX_WIDTH = 64;
    localparam int MIN_NBLK  = 2;
    localparam int MAX_NBLK  = 8;

    function automatic int cla_nblk(input int width, input int block);
        return width / block;
    endfunction

    // WIDTH must split into a whole number of blocks, and the block count
    // must stay within the range the lookahead expansion is built for.
    function automatic bit cla_params_ok(input int width, input int block);
        return (block > 0) &&
               (width % block == 0) &&
               (width / block >= MIN_NBLK) &&
               (width / block <= MAX_NBLK) &&
               (width <= MAX_WIDTH);
    endfunction

    localparam bit DEF_PARAMS_OK = cla_params_ok(DEF_WIDTH, DEF_BLOCK);

    typedef struct packed {
        logic [MAX_NBLK-1:0]  blk_p;
        logic [MAX_NBLK-1:0]  blk_g;
        logic [MAX_WIDTH-1:0] sum0;
        logic [MAX_WIDTH-1:0] sum1;
        logic                 cin;
        logic                 a_msb;
        logic                 b_msb;
    } s1_payload_t;

endpackage

// File: rtl/cla_pipe_adder_if.sv
// -----------------------------------------------------------------------------
// cla_pipe_adder_if
// Handshake and data bundle for cla_pipe_adder.
//   Request side : in_valid, in_ready, a, b, c_in, sub
//   Response side: out_valid, out_ready, s, c_out, ovf
// modport slave  : the adder (consumes requests, produces responses)
// modport master : the ALU side (produces requests, consumes responses)
// -----------------------------------------------------------------------------
interface cla_pipe_adder_if
    import cla_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             sub;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             c_out;
    logic             ovf;

    modport master (
        output in_valid, a, b, c_in, sub, out_ready,
        input  in_ready, out_valid, s, c_out, ovf
    );

    modport slave (
        input  in_valid, a, b, c_in, sub, out_ready,
        output in_ready, out_valid, s, c_out, ovf
    );

endinterface

// File: rtl/cla_pipe_block.sv
// -----------------------------------------------------------------------------
// cla_pipe_block
// Combinational BLOCK-bit slice of the carry-select lookahead adder.
//   a, b  : operand slices (b already conditionally inverted for subtract)
//   p     : block propagate, AND of the per-bit OR-propagates
//   g     : block generate, carry out of the block with carry-in 0
//   sum0  : slice sum assuming carry-in 0
//   sum1  : slice sum assuming carry-in 1
// -----------------------------------------------------------------------------
module cla_pipe_block
    import cla_pkg::*;
#(
    parameter int BLOCK = DEF_BLOCK
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    output logic             p,
    output logic             g,
    output logic [BLOCK-1:0] sum0,
    output logic [BLOCK-1:0] sum1
);

    logic [BLOCK-1:0] bit_p;
    logic [BLOCK-1:0] bit_g;
    logic             g_acc;

    assign bit_p = a | b;
    assign bit_g = a & b;

    // With OR-propagate a generating bit also propagates, so folding the
    // generates from LSB to MSB yields the block carry-out for carry-in 0.
    always_comb begin
        g_acc = 1'b0;
        for (int i = 0; i < BLOCK; i++) begin
            g_acc = bit_g[i] | (bit_p[i] & g_acc);
        end
    end

    assign p    = &bit_p;
    assign g    = g_acc;
    assign sum0 = a + b;
    assign sum1 = a + b + BLOCK'(1);

endmodule

// File: rtl/cla_pipe_adder.sv
// -----------------------------------------------------------------------------
// cla_pipe_adder
// Two-stage pipelined carry-select / carry-lookahead adder-subtractor.
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : cla_pipe_adder_if.slave (valid/ready request and response)
// Stage 1 registers per-block P/G and both candidate sums on accept.
// Stage 2 resolves block carries with a flattened lookahead, selects the
// block sums and registers s/c_out/ovf. Latency 2, throughput 1/cycle.
// in_ready depends combinationally on out_ready so a full pipe can accept
// and deliver in the same cycle.
// -----------------------------------------------------------------------------
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int BLOCK = DEF_BLOCK
) (
    input  logic            clock,
    input  logic            reset_n,
    cla_pipe_adder_if.slave bus
);

    localparam int NBLK = cla_nblk(WIDTH, BLOCK);

    if (!cla_params_ok(WIDTH, BLOCK)) begin : g_param_check
        $error("cla_pipe_adder: WIDTH must be a multiple of BLOCK giving 2..8 blocks, WIDTH <= 64");
    end

    logic             accept;
    logic             adv2;
    logic             in_ready;

    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    logic [NBLK-1:0]  blk_p;
    logic [NBLK-1:0]  blk_g;
    logic [WIDTH-1:0] blk_sum0;
    logic [WIDTH-1:0] blk_sum1;

    logic             s1_valid_d, s1_valid_q;
    s1_payload_t      s1_d, s1_q;
    logic             s2_valid_d, s2_valid_q;
    logic [WIDTH-1:0] s_d, s_q;
    logic             c_out_d, c_out_q;
    logic             ovf_d, ovf_q;

    logic [NBLK-1:0]  st_p;
    logic [NBLK-1:0]  st_g;
    logic [NBLK:0]    carry;
    logic             term;
    logic             acc;
    logic [WIDTH-1:0] sum_sel;

    // Payload bits above WIDTH/NBLK are constant zero; reduce them here so
    // every payload bit has a reader regardless of geometry.
    logic             unused_s1;
    assign unused_s1 = ^s1_q;

    // Subtract is a + ~b + 1; the caller's carry-in only matters when adding.
    assign b_eff   = bus.sub ? ~bus.b : bus.b;
    assign cin_eff = bus.sub ? 1'b1 : bus.c_in;

    // Handshake: stage 2 moves when its slot is empty or being drained,
    // stage 1 accepts when empty or moving on in the same cycle.
    assign adv2     = s1_valid_q & (~s2_valid_q | bus.out_ready);
    assign in_ready = ~s1_valid_q | adv2;
    assign accept   = bus.in_valid & in_ready;

    for (genvar k = 0; k < NBLK; k++) begin : g_blk
        cla_pipe_block #(
            .BLOCK (BLOCK)
        ) u_blk (
            .a    (bus.a[k*BLOCK +: BLOCK]),
            .b    (b_eff[k*BLOCK +: BLOCK]),
            .p    (blk_p[k]),
            .g    (blk_g[k]),
            .sum0 (blk_sum0[k*BLOCK +: BLOCK]),
            .sum1 (blk_sum1[k*BLOCK +: BLOCK])
        );
    end

    // Stage 1 next state: capture a fresh payload only on accept, otherwise
    // hold so nothing in the pipe changes on idle input cycles.
    always_comb begin
        s1_d       = s1_q;
        s1_valid_d = s1_valid_q;
        if (accept) begin
            s1_d       = '0;
            s1_d.blk_p = MAX_NBLK'(blk_p);
            s1_d.blk_g = MAX_NBLK'(blk_g);
            s1_d.sum0  = MAX_WIDTH'(blk_sum0);
            s1_d.sum1  = MAX_WIDTH'(blk_sum1);
            s1_d.cin   = cin_eff;
            s1_d.a_msb = bus.a[WIDTH-1];
            s1_d.b_msb = b_eff[WIDTH-1];
            s1_valid_d = 1'b1;
        end else if (adv2) begin
            s1_valid_d = 1'b0;
        end
    end

    assign st_p = s1_q.blk_p[NBLK-1:0];
    assign st_g = s1_q.blk_g[NBLK-1:0];

    // Block carries as a two-level sum of products:
    // c[k+1] = G_k | P_k G_(k-1) | ... | P_k..P_1 G_0 | P_k..P_0 cin.
    // Each product term is built independently so no carry depends on
    // another block's resolved carry.
    always_comb begin
        carry    = '0;
        term     = 1'b0;
        acc      = 1'b0;
        carry[0] = s1_q.cin;
        for (int k = 0; k < NBLK; k++) begin
            term = s1_q.cin;
            for (int i = 0; i <= k; i++) begin
                term = term & st_p[i];
            end
            acc = term;
            for (int j = 0; j <= k; j++) begin
                term = st_g[j];
                for (int i = j + 1; i <= k; i++) begin
                    term = term & st_p[i];
                end
                acc = acc | term;
            end
            carry[k+1] = acc;
        end
    end

    // Carry-select: each block picks the candidate matching its carry-in.
    always_comb begin
        sum_sel = '0;
        for (int k = 0; k < NBLK; k++) begin
            sum_sel[k*BLOCK +: BLOCK] = carry[k] ? s1_q.sum1[k*BLOCK +: BLOCK]
                                                 : s1_q.sum0[k*BLOCK +: BLOCK];
        end
    end

    // Stage 2 next state: results only change when a new operation moves
    // in, so they stay put while the consumer stalls.
    always_comb begin
        s_d        = s_q;
        c_out_d    = c_out_q;
        ovf_d      = ovf_q;
        s2_valid_d = s2_valid_q;
        if (adv2) begin
            s_d        = sum_sel;
            c_out_d    = carry[NBLK];
            ovf_d      = (s1_q.a_msb == s1_q.b_msb) & (sum_sel[WIDTH-1] != s1_q.a_msb);
            s2_valid_d = 1'b1;
        end else if (bus.out_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    // Pipeline registers; reset discards anything in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_valid_q <= 1'b0;
            s_q        <= '0;
            c_out_q    <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_q       <= s1_d;
            s2_valid_q <= s2_valid_d;
            s_q        <= s_d;
            c_out_q    <= c_out_d;
            ovf_q      <= ovf_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = s2_valid_q;
    assign bus.s         = s_q;
    assign bus.c_out     = c_out_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// -----------------------------------------------------------------------------
// tb_cla_pipe_adder
// Directed and randomized checks of cla_pipe_adder in three geometries
// (32/8, 16/4, 64/16). The reference model works on whole-word integer
// arithmetic with wide signed sums for overflow.
// -----------------------------------------------------------------------------
module tb_cla_pipe_adder;

    logic clock = 1'b0;
    logic reset_n = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    cla_pipe_adder_if #(.WIDTH(32)) if32 ();
    cla_pipe_adder_if #(.WIDTH(16)) if16 ();
    cla_pipe_adder_if #(.WIDTH(64)) if64 ();

    cla_pipe_adder #(.WIDTH(32), .BLOCK(8))  dut32 (.clock(clock), .reset_n(reset_n), .bus(if32));
    cla_pipe_adder #(.WIDTH(16), .BLOCK(4))  dut16 (.clock(clock), .reset_n(reset_n), .bus(if16));
    cla_pipe_adder #(.WIDTH(64), .BLOCK(16)) dut64 (.clock(clock), .reset_n(reset_n), .bus(if64));

    // Reference: integer add of a, (b or its complement) and carry-in; overflow
    // is the true signed result falling outside the w-bit signed range.
    function automatic void ref_model(input int w, input logic [63:0] a, input logic [63:0] b,
                                      input logic cin, input logic sub,
                                      output logic [63:0] s, output logic co, output logic ovf);
        logic [63:0] mask;
        logic [63:0] beff;
        logic        ce;
        logic [64:0] full;
        logic signed [65:0] sa, sb, ssum, smax, smin;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        beff = sub ? (~b & mask) : (b & mask);
        ce   = sub ? 1'b1 : cin;
        full = {1'b0, a & mask} + {1'b0, beff} + {64'd0, ce};
        s    = full[63:0] & mask;
        co   = full[w];
        sa   = a[w-1]    ? $signed({2'b11, a | ~mask})    : $signed({2'b00, a & mask});
        sb   = beff[w-1] ? $signed({2'b11, beff | ~mask}) : $signed({2'b00, beff});
        ssum = sa + sb + $signed({65'd0, ce});
        smax = (66'sd1 <<< (w - 1)) - 66'sd1;
        smin = -(66'sd1 <<< (w - 1));
        ovf  = (ssum > smax) || (ssum < smin);
    endfunction

    task automatic drive(input int which, input logic v, input logic [63:0] a, input logic [63:0] b,
                         input logic cin, input logic sub, input logic rdy);
        case (which)
            0: begin
                if32.in_valid = v; if32.a = a[31:0]; if32.b = b[31:0];
                if32.c_in = cin; if32.sub = sub; if32.out_ready = rdy;
            end
            1: begin
                if16.in_valid = v; if16.a = a[15:0]; if16.b = b[15:0];
                if16.c_in = cin; if16.sub = sub; if16.out_ready = rdy;
            end
            default: begin
                if64.in_valid = v; if64.a = a; if64.b = b;
                if64.c_in = cin; if64.sub = sub; if64.out_ready = rdy;
            end
        endcase
    endtask

    task automatic sample(input int which, output logic ir, output logic ov, output logic [63:0] s,
                          output logic co, output logic ovf);
        case (which)
            0: begin ir = if32.in_ready; ov = if32.out_valid; s = {32'd0, if32.s}; co = if32.c_out; ovf = if32.ovf; end
            1: begin ir = if16.in_ready; ov = if16.out_valid; s = {48'd0, if16.s}; co = if16.c_out; ovf = if16.ovf; end
            default: begin ir = if64.in_ready; ov = if64.out_valid; s = if64.s; co = if64.c_out; ovf = if64.ovf; end
        endcase
    endtask

    // Presents one operation for a single cycle with the consumer ready and
    // returns at the negedge after the accepting edge.
    task automatic launch32(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
        @(negedge clock);
        drive(0, 1'b1, {32'd0, a}, {32'd0, b}, cin, sub, 1'b1);
        @(negedge clock);
        if32.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) drive(i, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1);
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        vectors++;
        if ({if32.out_valid, if32.s, if32.c_out, if32.ovf} !== 35'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_state: got valid=%0b s=%h c=%0b v=%0b, want all 0",
                     if32.out_valid, if32.s, if32.c_out, if32.ovf);
        end
        reset_n = 1'b1;
        @(negedge clock);
        vectors++;
        if (if32.in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_in_ready: got %0b, want 1", if32.in_ready);
        end
    endtask

    task automatic test_add_wrap();
        launch32(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0);
        vectors++;
        if (if32.out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL wrap_latency1: out_valid got %0b, want 0", if32.out_valid);
        end
        @(negedge clock);
        vectors++;
        if ({if32.out_valid, if32.s, if32.c_out, if32.ovf} !== {1'b1, 32'h0, 1'b1, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL wrap_result: got valid=%0b s=%h c=%0b v=%0b, want 1 00000000 1 0",
                     if32.out_valid, if32.s, if32.c_out, if32.ovf);
        end
        @(negedge clock);
        vectors++;
        if (if32.out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL wrap_pulse: out_valid got %0b, want 0", if32.out_valid);
        end
    endtask

    task automatic test_subtract();
        launch32(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
        @(negedge clock);
        vectors++;
        if ({if32.out_valid, if32.s, if32.c_out, if32.ovf} !== {1'b1, 32'h8000_0000, 1'b0, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL sub_ovf: got valid=%0b s=%h c=%0b v=%0b, want 1 80000000 0 1",
                     if32.out_valid, if32.s, if32.c_out, if32.ovf);
        end
        launch32(32'd5, 32'd5, 1'b1, 1'b1);
        @(negedge clock);
        vectors++;
        if ({if32.out_valid, if32.s, if32.c_out, if32.ovf} !== {1'b1, 32'h0, 1'b1, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL sub_equal: got valid=%0b s=%h c=%0b v=%0b, want 1 00000000 1 0",
                     if32.out_valid, if32.s, if32.c_out, if32.ovf);
        end
    endtask

    task automatic test_block_carry();
        launch32(32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        @(negedge clock);
        vectors++;
        if ({if32.out_valid, if32.s, if32.c_out, if32.ovf} !== {1'b1, 32'h0100_0000, 1'b0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL block_chain: got valid=%0b s=%h c=%0b v=%0b, want 1 01000000 0 0",
                     if32.out_valid, if32.s, if32.c_out, if32.ovf);
        end
        launch32(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
        @(negedge clock);
        vectors++;
        if ({if32.out_valid, if32.s, if32.c_out, if32.ovf} !== {1'b1, 32'h0, 1'b1, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL full_chain_cin: got valid=%0b s=%h c=%0b v=%0b, want 1 00000000 1 0",
                     if32.out_valid, if32.s, if32.c_out, if32.ovf);
        end
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        int got = 0;
        int cyc = 0;
        logic [31:0] exp;
        while (got < 4 && cyc < 40) begin
            @(negedge clock);
            drive(0, sent < 4, 64'(sent), 64'h0F0F_0F0F, 1'b0, 1'b0, cyc >= 5);
            #1;
            if (cyc >= 2 && cyc <= 4) begin
                vectors++;
                if ({if32.in_ready, if32.out_valid, if32.s} !== {1'b0, 1'b1, 32'h0F0F_0F0F}) begin
                    miscompares++;
                    $display("[TB] FAIL b2b_stall cyc%0d: got rdy=%0b valid=%0b s=%h, want 0 1 0f0f0f0f",
                             cyc, if32.in_ready, if32.out_valid, if32.s);
                end
            end
            if (if32.out_valid && if32.out_ready) begin
                exp = 32'h0F0F_0F0F + 32'(got);
                vectors++;
                if ({if32.s, if32.c_out, if32.ovf} !== {exp, 1'b0, 1'b0}) begin
                    miscompares++;
                    $display("[TB] FAIL b2b_order #%0d: got s=%h c=%0b v=%0b, want %h 0 0",
                             got, if32.s, if32.c_out, if32.ovf, exp);
                end
                got++;
            end
            if (if32.in_valid && if32.in_ready) sent++;
            cyc++;
        end
        vectors++;
        if (got != 4) begin
            miscompares++;
            $display("[TB] FAIL b2b_count: got %0d results, want 4", got);
        end
        if32.in_valid = 1'b0;
        repeat (3) begin
            @(negedge clock);
            vectors++;
            if (if32.out_valid !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL b2b_no_dup: out_valid got %0b, want 0", if32.out_valid);
            end
        end
    endtask

    task automatic test_reset_inflight();
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            drive(0, 1'b1, 64'(i + 100), 64'd7, 1'b0, 1'b0, 1'b0);
        end
        @(negedge clock);
        if32.in_valid = 1'b0;
        vectors++;
        if (if32.out_valid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL inflight_pre: out_valid got %0b, want 1", if32.out_valid);
        end
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if (if32.out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL inflight_async: out_valid got %0b, want 0", if32.out_valid);
        end
        @(negedge clock);
        reset_n = 1'b1;
        if32.out_ready = 1'b1;
        repeat (4) begin
            @(negedge clock);
            vectors++;
            if ({if32.out_valid, if32.in_ready} !== 2'b01) begin
                miscompares++;
                $display("[TB] FAIL inflight_stale: got valid=%0b rdy=%0b, want 0 1",
                         if32.out_valid, if32.in_ready);
            end
        end
    endtask

    task automatic test_random(input int which, input int w, input int n);
        logic [65:0] exp_q[$];
        logic [65:0] e;
        logic [63:0] mask, ra, rb, ms, ss;
        logic rc, rs, rr, v, mco, movf, ir, ov, sco, sovf;
        int sent = 0;
        int got = 0;
        int cycles = 0;
        int budget = 6 * n + 200;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        while ((sent < n || got < sent) && cycles < budget) begin
            @(negedge clock);
            cycles++;
            v  = (sent < n) && ($urandom_range(0, 9) < 8);
            ra = {$urandom(), $urandom()} & mask;
            rb = {$urandom(), $urandom()} & mask;
            rc = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            rr = ($urandom_range(0, 3) != 0);
            drive(which, v, ra, rb, rc, rs, rr);
            #1;
            sample(which, ir, ov, ss, sco, sovf);
            if (ov && rr) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL rand%0d_extra: got s=%h with nothing outstanding", w, ss);
                end else begin
                    e = exp_q.pop_front();
                    if ({ss, sco, sovf} !== e) begin
                        miscompares++;
                        $display("[TB] FAIL rand%0d #%0d: got s=%h c=%0b v=%0b, want s=%h c=%0b v=%0b",
                                 w, got, ss, sco, sovf, e[65:2], e[1], e[0]);
                    end
                end
                got++;
            end
            if (v && ir) begin
                ref_model(w, ra, rb, rc, rs, ms, mco, movf);
                exp_q.push_back({ms, mco, movf});
                sent++;
            end
        end
        drive(which, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1);
        vectors++;
        if (got != n || sent != n) begin
            miscompares++;
            $display("[TB] FAIL rand%0d_drain: sent %0d received %0d, want %0d each", w, sent, got, n);
        end
    endtask

    initial begin
        test_reset();
        test_add_wrap();
        test_subtract();
        test_block_carry();
        test_back_to_back();
        test_reset_inflight();
        test_random(0, 32, 2000);
        test_random(1, 16, 10000);
        test_random(2, 64, 10000);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cla_pipe_adder.md
Name: cla_pipe_adder

Overview:
- Parametrised, two-stage pipelined carry-lookahead adder/subtractor. Successor to the fixed 32-bit, 4x8-bit-block combinational CLA.
- Sits between the ALU operand muxes and the ALU result mux.
- Adds a valid/ready handshake, a subtract mode, carry-out and signed overflow flags, and back-pressure so the ALU can stall without losing operands.

Parameters:
- WIDTH, 32: operand/result width; must be a multiple of BLOCK.
- BLOCK, 8: bits per lookahead block; NBLK = WIDTH/BLOCK, legal range 2..8.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands present.
- in_ready  out  1  stage 1 can accept this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- c_in  in  1  carry in (add mode only).
- sub  in  1  1 = compute a - b.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- s  out  WIDTH  sum/difference.
- c_out  out  1  carry out of MSB (sub: 1 = no borrow).
- ovf  out  1  signed two's-complement overflow.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - s1_valid=0, s2_valid=0.
  - out_valid=0, s=0, c_out=0, ovf=0.
  - in_ready=1 from the first cycle after release.
- Operand prep:
  - b_eff = sub ? ~b : b.
  - cin_eff = sub ? 1 : c_in; c_in is ignored when sub=1.
- Stage 1 (registered on accept, i.e. in_valid & in_ready), per block k:
  - p = a|b_eff, g = a&b_eff (same OR-propagate / AND-generate convention as the existing CLA).
  - Block P_k, block G_k.
  - Two candidate sums: sum0_k (carry-in 0) and sum1_k (carry-in 1).
  - Also registered: cin_eff, a[MSB], b_eff[MSB].
- Stage 2 (registered when s2 slot free or out_ready):
  - c[0] = cin_eff; c[k+1] = G_k | P_k & c[k], expanded as full lookahead, not ripple.
  - s block k = c[k] ? sum1_k : sum0_k.
  - c_out = c[NBLK].
  - ovf = (a_msb == b_eff_msb) & (s_msb != a_msb).
- Latency: exactly 2 cycles from accept to out_valid with no stall. Throughput: 1 per cycle.
- Handshake:
  - adv2 = s1_valid & (!s2_valid | out_ready).
  - in_ready = !s1_valid | adv2 (combinational from out_ready; no bubble).
  - Output fields hold stable while out_valid & !out_ready.
  - out_valid drops after a transfer only if no new data advances that cycle.
- Simultaneous accept and output transfer in the same cycle: both occur; the pipe stays full.
- Inputs are don't-care when in_valid=0. No registers update on non-accept.
- Reset mid-operation: in-flight operations are discarded, no partial output. out_valid falls asynchronously with reset_n.
- Wrap-around is modulo 2^WIDTH. Carry and overflow are reported, never saturated.

Decomposition:
- Package cla_pkg holds:
  - Default WIDTH/BLOCK constants.
  - A function returning NBLK.
  - An elaboration check that WIDTH % BLOCK == 0.
  - Typedef for the stage-1 payload struct (P, G, sum0, sum1, cin, msbs).
- Sub-module cla_pipe_block (BLOCK-bit): produces P, G, sum0, sum1. It is combinational and is instantiated NBLK times in stage 1.
- Lookahead carry generation stays in the top level.

Test Plan:
- Reset, then add 0x0000_0001 + 0xFFFF_FFFF, c_in=0, out_ready=1 -> 2 cycles later s=0x0, c_out=1, ovf=0, out_valid high one cycle.
- sub=1, a=0x7FFF_FFFF, b=0xFFFF_FFFF -> s=0x8000_0000, c_out=0, ovf=1. Also sub=1, a=5, b=5 -> s=0, c_out=1, ovf=0.
- Back-to-back 4 adds (i+0x0F0F_0F0F, i=0..3) with out_ready held 0 for cycles 3-5:
  - in_ready falls after 2 accepts.
  - Results arrive in order with no loss or duplication once out_ready=1.
  - s stays stable while stalled.
- Block-boundary carry chain: a=0x00FF_FFFF, b=0x1, c_in=0 -> s=0x0100_0000. Repeat with c_in=1 and a=0xFFFF_FFFF, b=0 -> s=0, c_out=1.
- Assert reset_n low with two operations in flight -> out_valid=0 immediately. After release, no stale results appear and in_ready=1.
- Parameter sweep WIDTH=16/BLOCK=4 and WIDTH=64/BLOCK=16: 10k random a/b/c_in/sub with random out_ready -> s, c_out and ovf match the reference model, in order.
